// File: rtl/wb.sv
// MEM/WB pipeline register with write-back mux and register-0 write suppression.
// Define WB_LOAD_EXT_EN to add LoadType_In and byte/halfword load extension on the memory path.
module wb #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [DATA_W-1:0] Address_In,
  input  logic [1:0]        WBControl_In,
  input  logic [DATA_W-1:0] Data_In,
  input  logic [REG_W-1:0]  WriteReg_In,
  input  logic              Stall_In,
  input  logic              Flush_In,
`ifdef WB_LOAD_EXT_EN
  input  logic [2:0]        LoadType_In,
`endif
  output logic [DATA_W-1:0] Data_Out,
  output logic              RegWrite_Out,
  output logic [REG_W-1:0]  WriteReg_Out
);

  logic [DATA_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [1:0]        ctrl_q;
  logic [REG_W-1:0]  wreg_q;
  logic [DATA_W-1:0] mem_data;

  // Flush beats stall so a squashed instruction can never be held in place.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      addr_q <= '0;
      data_q <= '0;
      ctrl_q <= '0;
      wreg_q <= '0;
    end else if (Flush_In) begin
      addr_q <= '0;
      data_q <= '0;
      ctrl_q <= '0;
      wreg_q <= '0;
    end else if (!Stall_In) begin
      addr_q <= Address_In;
      data_q <= Data_In;
      ctrl_q <= WBControl_In;
      wreg_q <= WriteReg_In;
    end
  end

`ifdef WB_LOAD_EXT_EN
  logic [2:0] ltype_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ltype_q <= '0;
    end else if (Flush_In) begin
      ltype_q <= '0;
    end else if (!Stall_In) begin
      ltype_q <= LoadType_In;
    end
  end

  always_comb begin
    mem_data = data_q;
    case (ltype_q)
      3'b001:  mem_data = {{(DATA_W-8){data_q[7]}}, data_q[7:0]};
      3'b010:  mem_data = {{(DATA_W-8){1'b0}}, data_q[7:0]};
      3'b011:  mem_data = {{(DATA_W-16){data_q[15]}}, data_q[15:0]};
      3'b100:  mem_data = {{(DATA_W-16){1'b0}}, data_q[15:0]};
      default: mem_data = data_q;
    endcase
  end
`else
  assign mem_data = data_q;
`endif

  assign Data_Out     = ctrl_q[0] ? mem_data : addr_q;
  assign RegWrite_Out = ctrl_q[1] && (wreg_q != '0);
  assign WriteReg_Out = wreg_q;

endmodule

// File: tb/tb_wb.sv
// Self-checking bench for wb: directed vector table, multi-cycle reset/hold sequences,
// and randomized traffic against a transaction-level model.
module tb_wb;
  localparam int DW = 32;
  localparam int RW = 5;

  logic          Clk = 1'b0;
  logic          Reset_n;
  logic [DW-1:0] Address_In;
  logic [1:0]    WBControl_In;
  logic [DW-1:0] Data_In;
  logic [RW-1:0] WriteReg_In;
  logic          Stall_In;
  logic          Flush_In;
  logic [2:0]    lt;
  logic [DW-1:0] Data_Out;
  logic          RegWrite_Out;
  logic [RW-1:0] WriteReg_Out;

  int total = 0;
  int bad   = 0;

  always #5 Clk = ~Clk;

  wb #(.DATA_W(DW), .REG_W(RW)) dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .Address_In   (Address_In),
    .WBControl_In (WBControl_In),
    .Data_In      (Data_In),
    .WriteReg_In  (WriteReg_In),
    .Stall_In     (Stall_In),
    .Flush_In     (Flush_In),
`ifdef WB_LOAD_EXT_EN
    .LoadType_In  (lt),
`endif
    .Data_Out     (Data_Out),
    .RegWrite_Out (RegWrite_Out),
    .WriteReg_Out (WriteReg_Out)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [1:0]  c;
    logic [4:0]  w;
    logic        s;
    logic        f;
    logic [2:0]  t;
    logic [31:0] ed;
    logic        ewe;
    logic [4:0]  ew;
  } vec_t;

  // One captured instruction, as the model sees it.
  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic        reg_write;
    logic        mem_to_reg;
    logic [4:0]  w;
    logic [2:0]  t;
  } instr_t;

  vec_t   vecs[10];
  instr_t m;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [1:0] c,
                       input logic [4:0] w, input logic s, input logic f, input logic [2:0] t);
    Address_In   = a;
    Data_In      = d;
    WBControl_In = c;
    WriteReg_In  = w;
    Stall_In     = s;
    Flush_In     = f;
    lt           = t;
  endtask

  task automatic check_outs(input string nm, input logic [31:0] ed, input logic ewe, input logic [4:0] ew);
    check({nm, ".data"}, Data_Out, ed);
    check({nm, ".we"}, {31'd0, RegWrite_Out}, {31'd0, ewe});
    check({nm, ".wreg"}, {27'd0, WriteReg_Out}, {27'd0, ew});
  endtask

  function automatic logic [31:0] model_load(input logic [31:0] d, input logic [2:0] t);
`ifdef WB_LOAD_EXT_EN
    int v;
    case (t)
      3'd1: begin v = int'(d % 256);   if (v >= 128)   v -= 256;   return v; end
      3'd2: return d % 256;
      3'd3: begin v = int'(d % 65536); if (v >= 32768) v -= 65536; return v; end
      3'd4: return d % 65536;
      default: return d;
    endcase
`else
    return d + 32'd0 * t;
`endif
  endfunction

  function automatic logic [31:0] model_data(input instr_t x);
    return x.mem_to_reg ? model_load(x.d, x.t) : x.a;
  endfunction

  initial begin
    vecs[0] = '{32'd1, 32'd2, 2'b11, 5'd3, 1'b0, 1'b0, 3'd0, 32'd2, 1'b1, 5'd3};
    vecs[1] = '{32'd1, 32'd2, 2'b10, 5'd3, 1'b0, 1'b0, 3'd0, 32'd1, 1'b1, 5'd3};
    vecs[2] = '{32'd1, 32'd2, 2'b01, 5'd3, 1'b0, 1'b0, 3'd0, 32'd2, 1'b0, 5'd3};
    vecs[3] = '{32'd1, 32'd2, 2'b11, 5'd0, 1'b0, 1'b0, 3'd0, 32'd2, 1'b0, 5'd0};
    vecs[4] = '{32'd1, 32'd2, 2'b11, 5'd3, 1'b0, 1'b0, 3'd0, 32'd2, 1'b1, 5'd3};
    vecs[5] = '{32'd5, 32'd6, 2'b10, 5'd7, 1'b1, 1'b0, 3'd0, 32'd2, 1'b1, 5'd3};
    vecs[6] = '{32'd5, 32'd6, 2'b11, 5'd7, 1'b1, 1'b1, 3'd0, 32'd0, 1'b0, 5'd0};
    vecs[7] = '{32'd9, 32'd9, 2'b11, 5'd9, 1'b0, 1'b1, 3'd0, 32'd0, 1'b0, 5'd0};
    vecs[8] = '{32'hDEADBEEF, 32'h12345678, 2'b10, 5'd31, 1'b0, 1'b0, 3'd0, 32'hDEADBEEF, 1'b1, 5'd31};
    vecs[9] = '{32'hDEADBEEF, 32'h12345678, 2'b01, 5'd31, 1'b0, 1'b0, 3'd0, 32'h12345678, 1'b0, 5'd31};

    Reset_n = 1'b0;
    drive(32'hA5A5A5A5, 32'h5A5A5A5A, 2'b11, 5'd4, 1'b0, 1'b0, 3'd0);
    #12;
    check_outs("reset", 32'd0, 1'b0, 5'd0);
    @(negedge Clk);
    Reset_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].a, vecs[i].d, vecs[i].c, vecs[i].w, vecs[i].s, vecs[i].f, vecs[i].t);
      @(posedge Clk);
      #1;
      check_outs($sformatf("vec%0d", i), vecs[i].ed, vecs[i].ewe, vecs[i].ew);
    end

    // Inputs wiggling between edges must not reach the outputs.
    drive(32'h11111111, 32'h22222222, 2'b10, 5'd1, 1'b0, 1'b0, 3'd0);
    #2;
    check_outs("between_edges", 32'h12345678, 1'b0, 5'd31);

    // Asynchronous reset mid-operation, then first edge after release captures.
    @(negedge Clk);
    drive(32'd1, 32'd2, 2'b11, 5'd3, 1'b0, 1'b0, 3'd0);
    @(posedge Clk);
    #1;
    check_outs("preload", 32'd2, 1'b1, 5'd3);
    #2;
    Reset_n = 1'b0;
    #1;
    check_outs("async_reset", 32'd0, 1'b0, 5'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    @(posedge Clk);
    #1;
    check_outs("post_reset", 32'd2, 1'b1, 5'd3);

`ifdef WB_LOAD_EXT_EN
    @(negedge Clk);
    drive(32'h0, 32'h000000F0, 2'b11, 5'd3, 1'b0, 1'b0, 3'b001);
    @(posedge Clk); #1;
    check("ext_lb", Data_Out, 32'hFFFFFFF0);
    @(negedge Clk);
    drive(32'h0, 32'h000000F0, 2'b11, 5'd3, 1'b0, 1'b0, 3'b010);
    @(posedge Clk); #1;
    check("ext_lbu", Data_Out, 32'h000000F0);
    @(negedge Clk);
    drive(32'h0, 32'h12348000, 2'b11, 5'd3, 1'b0, 1'b0, 3'b011);
    @(posedge Clk); #1;
    check("ext_lh", Data_Out, 32'hFFFF8000);
    @(negedge Clk);
    drive(32'h000000F0, 32'h0, 2'b10, 5'd3, 1'b0, 1'b0, 3'b001);
    @(posedge Clk); #1;
    check("ext_alu", Data_Out, 32'h000000F0);
`endif

    // Randomized traffic against the instruction-level model, starting from reset.
    @(negedge Clk);
    Reset_n = 1'b0;
    m = '{32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 3'd0};
    #1;
    Reset_n = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge Clk);
      drive($urandom, $urandom, 2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0), 3'($urandom_range(0, 7)));
      if (Flush_In)
        m = '{32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 3'd0};
      else if (!Stall_In)
        m = '{Address_In, Data_In, WBControl_In[1], WBControl_In[0], WriteReg_In, lt};
      @(posedge Clk);
      #1;
      check_outs($sformatf("rand%0d", i), model_data(m), m.reg_write && (m.w != 0), m.w);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
